// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
package serial_adder_ctrl_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operation select encodings.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Conditionally invert operand B for subtraction (two's complement with carry-in = 1).
    function automatic logic [63:0] prep_b(input logic [63:0] b_val, input logic op_val);
        return (op_val == OP_SUB) ? ~b_val : b_val;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the single arithmetic cell of the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one result bit per clock, LSB first,
// through a single full adder. Results appear on sum/cout/ovf only when done.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e             state_q;
    state_e             state_d;
    // a_q doubles as the result shift register: result bits enter at the MSB
    // as operand bits leave at the LSB, so after WIDTH steps it holds the result.
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               load_s;
    logic               step_s;
    logic               last_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [63:0]        b_prep_s;

    assign last_s   = (cnt_q == CNT_LAST);
    assign b_prep_s = prep_b(64'(b), op);

    full_adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum_s),
        .Cout (fa_cout_s)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; reset overrides any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shift registers, carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else if (load_s) begin
            a_q     <= a;
            b_q     <= b_prep_s[WIDTH-1:0];
            carry_q <= op;
            cnt_q   <= {CNT_W{1'b0}};
        end else if (step_s) begin
            a_q     <= {fa_sum_s, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            carry_q <= fa_cout_s;
            // Return to zero on the final step instead of wrapping.
            cnt_q   <= last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
        end else begin
            a_q     <= a_q;
            b_q     <= b_q;
            carry_q <= carry_q;
            cnt_q   <= cnt_q;
        end
    end

    // Result capture on the final RUN step only, so partial shifts stay hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= {WIDTH{1'b0}};
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (step_s && last_s) begin
            sum_q  <= {fa_sum_s, a_q[WIDTH-1:1]};
            cout_q <= fa_cout_s;
            // carry_q here is the carry into the MSB.
            ovf_q  <= carry_q ^ fa_cout_s;
        end else begin
            sum_q  <= sum_q;
            cout_q <= cout_q;
            ovf_q  <= ovf_q;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
